// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//
// Purpose: bundles the request/redirect inputs and the fetch/flush/mepc
// outputs of the program-counter sequencer into one interface.
//
// Parameter:
//   DATA_WIDTH  width of the PC and every address signal
//
// Signals (named from the sequencer's point of view):
//   i_fetch_ready    fetch unit accepts o_pc this cycle
//   i_stall          pipeline stall, blocks the sequential advance only
//   i_branch_taken   execute-stage redirect request
//   i_branch_target  redirect target
//   i_trap           exception/interrupt request
//   i_trap_vector    trap handler address (mtvec)
//   i_trap_epc       PC of the faulting instruction
//   i_mret           return-from-trap request
//   i_mepc           return address from the CSR file
//   i_halt           debug halt request
//   i_resume         debug resume request
//   o_pc             current PC presented to fetch
//   o_fetch_valid    o_pc is a valid fetch request
//   o_flush          squash in-flight fetch/decode
//   o_mepc_we        write strobe for mepc
//   o_mepc_data      value to write to mepc
//   o_halted         core is in the debug HALT state
//
// Modports:
//   master  the sequencer itself (consumes i_*, drives o_*)
//   slave   the surrounding pipeline/CSR/fetch logic
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_fetch_ready;
  logic                  i_stall;
  logic                  i_branch_taken;
  logic [DATA_WIDTH-1:0] i_branch_target;
  logic                  i_trap;
  logic [DATA_WIDTH-1:0] i_trap_vector;
  logic [DATA_WIDTH-1:0] i_trap_epc;
  logic                  i_mret;
  logic [DATA_WIDTH-1:0] i_mepc;
  logic                  i_halt;
  logic                  i_resume;
  logic [DATA_WIDTH-1:0] o_pc;
  logic                  o_fetch_valid;
  logic                  o_flush;
  logic                  o_mepc_we;
  logic [DATA_WIDTH-1:0] o_mepc_data;
  logic                  o_halted;

  modport master (
    input  i_fetch_ready, i_stall, i_branch_taken, i_branch_target,
           i_trap, i_trap_vector, i_trap_epc, i_mret, i_mepc,
           i_halt, i_resume,
    output o_pc, o_fetch_valid, o_flush, o_mepc_we, o_mepc_data, o_halted
  );

  modport slave (
    output i_fetch_ready, i_stall, i_branch_taken, i_branch_target,
           i_trap, i_trap_vector, i_trap_epc, i_mret, i_mepc,
           i_halt, i_resume,
    input  o_pc, o_fetch_valid, o_flush, o_mepc_we, o_mepc_data, o_halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose: owns the program counter and chooses its next value every cycle
// from boot vector, sequential advance, branch redirect, trap entry, mret
// return and debug halt. Drives the fetch request and issues flush and
// mepc-write strobes to the pipeline and CSR file.
//
// Ports:
//   clk     system clock
//   arst_n  reset, synchronous, active-low (sampled on posedge clk only)
//   bus     pc_sequencer_if.master, see the interface file for signals
//
// Parameters:
//   DATA_WIDTH    width of the PC and address signals
//   RESET_VECTOR  PC loaded on reset
//   INSTR_BYTES   sequential PC increment
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined    a taken branch whose target has bits[1:0] != 0 enters the
//              trap handler with mepc = branch target
//   undefined  the branch target is silently word-aligned
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(32'h3000_0000),
  parameter int unsigned           INSTR_BYTES  = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(INSTR_BYTES);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic                  mepcWe_q, mepcWe_d;
  logic [DATA_WIDTH-1:0] mepcData_q, mepcData_d;
  logic                  halted_q, halted_d;
  logic                  fetchValid;

  // The fetch request follows the stall input in the same cycle so that a
  // stall withdraws the request immediately instead of one cycle late.
  assign fetchValid = (state_q == RUN) && !bus.i_stall;

  // Next-state selection. Only one source wins per cycle; lower-priority
  // requests arriving together with a winner are dropped. Strobes default
  // to zero so they are single-cycle pulses.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    mepcWe_d   = 1'b0;
    mepcData_d = mepcData_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.i_trap) begin
          pc_d       = bus.i_trap_vector & ALIGN_MASK;
          mepcWe_d   = 1'b1;
          mepcData_d = bus.i_trap_epc;
          flush_d    = 1'b1;
          state_d    = TRAP;
        end else if (bus.i_mret) begin
          pc_d    = bus.i_mepc & ALIGN_MASK;
          flush_d = 1'b1;
        end else if (bus.i_branch_taken) begin
          flush_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
          if (bus.i_branch_target[1:0] != 2'b00) begin
            pc_d       = bus.i_trap_vector & ALIGN_MASK;
            mepcWe_d   = 1'b1;
            mepcData_d = bus.i_branch_target;
            state_d    = TRAP;
          end else begin
            pc_d = bus.i_branch_target;
          end
`else
          pc_d = bus.i_branch_target & ALIGN_MASK;
`endif
        end else if (bus.i_halt) begin
          state_d = HALT;
        end else if (fetchValid && bus.i_fetch_ready) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      TRAP: state_d = RUN;
      HALT: begin
        if (bus.i_resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALT);
  end

  // State and registered outputs. Reset is synchronous and wins over every
  // request, including a strobe that would otherwise be issued this cycle.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      flush_q    <= 1'b0;
      mepcWe_q   <= 1'b0;
      mepcData_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      mepcWe_q   <= mepcWe_d;
      mepcData_q <= mepcData_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_fetch_valid = fetchValid;
  assign bus.o_flush       = flush_q;
  assign bus.o_mepc_we     = mepcWe_q;
  assign bus.o_mepc_data   = mepcData_q;
  assign bus.o_halted      = halted_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter and decides its next value every cycle. It arbitrates between these PC sources: boot vector, sequential advance, branch/jump redirect, trap entry, mret return and debug halt. It drives the fetch request handshake, and issues flush and mepc-write strobes to the pipeline and CSR file. It sits between the execute/CSR stages and the instruction fetch unit.

Parameters:
DATA_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 32'h3000_0000, PC value loaded on reset
INSTR_BYTES, 4, sequential PC increment

Ports:
clk  input  1  system clock
arst_n  input  1  reset, synchronous, active-low
i_fetch_ready  input  1  fetch unit accepts o_pc this cycle
i_stall  input  1  pipeline stall; blocks sequential advance only
i_branch_taken  input  1  execute-stage redirect request
i_branch_target  input  DATA_WIDTH  redirect target
i_trap  input  1  exception/interrupt request
i_trap_vector  input  DATA_WIDTH  trap handler address (mtvec)
i_trap_epc  input  DATA_WIDTH  PC of faulting instruction
i_mret  input  1  return-from-trap request
i_mepc  input  DATA_WIDTH  return address from CSR file
i_halt  input  1  debug halt request
i_resume  input  1  debug resume request
o_pc  output  DATA_WIDTH  current PC presented to fetch
o_fetch_valid  output  1  o_pc is a valid fetch request
o_flush  output  1  squash in-flight fetch/decode
o_mepc_we  output  1  write strobe for mepc
o_mepc_data  output  DATA_WIDTH  value to write to mepc
o_halted  output  1  core is in HALT state

Behaviour:
- Interface: one clock, clk. Reset arst_n is synchronous and active-low, sampled only on posedge clk, and overrides every other input.
- Reset values: o_pc=RESET_VECTOR, state=BOOT, o_fetch_valid=0, o_flush=0, o_mepc_we=0, o_mepc_data=0, o_halted=0.
- States: BOOT, RUN, TRAP, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
  - o_fetch_valid=0.
  - All requests are ignored.
- RUN, fetch request:
  - o_fetch_valid = !i_stall.
- RUN, next-PC priority (highest first), evaluated once per cycle:
  1. i_trap:
     - Next o_pc = i_trap_vector with bits[1:0] cleared.
     - Registered outputs for one cycle: o_mepc_we=1, o_mepc_data=i_trap_epc, o_flush=1.
     - Go to TRAP.
  2. i_mret:
     - Next o_pc = i_mepc with bits[1:0] cleared.
     - o_flush=1 for one cycle.
     - Stay in RUN.
  3. i_branch_taken:
     - Next o_pc = i_branch_target; alignment is handled by the optional feature.
     - o_flush=1 for one cycle.
  4. i_halt:
     - PC holds; go to HALT.
  5. Sequential advance:
     - Condition: o_fetch_valid && i_fetch_ready.
     - Next o_pc = o_pc + INSTR_BYTES, modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
  6. Otherwise PC holds.
- Redirects (1-3) apply even while i_stall=1 or i_fetch_ready=0. Lower-priority requests in the same cycle are dropped, not queued.
- TRAP:
  - One bubble cycle: o_fetch_valid=0, all requests ignored.
  - Then return to RUN.
- HALT:
  - o_halted=1, o_fetch_valid=0, o_pc frozen.
  - i_resume moves to RUN next cycle.
  - i_trap in HALT is ignored.
- Strobes: o_flush and o_mepc_we are single-cycle pulses, registered, visible in the cycle after the request. o_mepc_data holds its last value when not written.
- Latency: a request in cycle N produces the new o_pc in cycle N+1.
- Reset mid-operation (any state, any pending strobe): next cycle matches the reset values and the state is BOOT.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a taken branch with i_branch_target[1:0]!=0 is handled as a trap.
  - Next o_pc = i_trap_vector with bits[1:0] cleared.
  - o_mepc_data = i_branch_target, o_mepc_we=1, o_flush=1.
  - State goes to TRAP.
  - Priority is still below i_trap and i_mret.
- Undefined: bits[1:0] of the branch target are forced to 0 and no trap is raised.

Test Plan:
- Reset/boot: arst_n=0 for 2 cycles, then 1; i_fetch_ready=1 → o_pc=0x3000_0000 with o_fetch_valid=0 for one cycle, then o_fetch_valid=1 and o_pc steps 0x3000_0000, 0x3000_0004, 0x3000_0008.
- Stall and backpressure: i_stall=1 or i_fetch_ready=0 at o_pc=0x3000_0010 → o_pc holds 0x3000_0010; release both → next cycle o_pc=0x3000_0014.
- Priority collision: i_trap=1 (vector 0x0000_0100, epc 0x3000_0020), i_mret=1 and i_branch_taken=1 in the same cycle → o_pc=0x0000_0100, o_mepc_we=1, o_mepc_data=0x3000_0020, o_flush=1, one bubble cycle, then o_pc=0x0000_0104.
- Return and wrap-around: i_mret with i_mepc=0xFFFF_FFFC → o_pc=0xFFFF_FFFC and o_flush=1; one accepted fetch later o_pc=0x0000_0000.
- Halt/resume: i_halt at o_pc=0x3000_0040 → o_halted=1 and o_fetch_valid=0 for 5 cycles with i_trap pulsed (ignored); i_resume → RUN at o_pc=0x3000_0040.
- Misaligned branch: target 0x3000_0052 → with MISALIGN_TRAP_EN, o_pc=trap vector and o_mepc_data=0x3000_0052; without it, o_pc=0x3000_0050 and no o_mepc_we. Additionally assert arst_n=0 in the o_flush cycle → next cycle matches the reset values.
